// File: rtl/serial_quant_packer.sv
// serial_quant_packer: captures one cache block of words and their quantization
// metadata, quantizes LANES words per clock and packs the variable-width codes
// LSB-first into one L2-line-wide word.
// Optional build macro: SERIAL_QUANT_RAW_OUTLIER_EN packs words flagged as
// outliers as their raw input value (full word width) instead of as a code.

// One-word quantizer: (word - mid), optionally arithmetic-shifted right by the
// step exponent, with bool bytes collapsed to 0/1. A word is an outlier when
// its code does not fit a signed field of bitWidth bits (bitWidth 0 never is).
module OneWayQuantizer #(
    parameter int W  = 32,
    parameter int EL = 8,
    parameter int NB = 4
) (
    input  logic [W-1:0]  word,
    input  logic [W-1:0]  mid,
    input  logic [EL-1:0] stepSize,
    input  logic [4:0]    bitWidth,
    input  logic          conv,
    input  logic [NB-1:0] isBool,
    output logic [W-1:0]  code,
    output logic          isOutlier
);
    localparam int BYW = W / NB;

    logic signed [W-1:0] diff, shifted, hi;

    // quantize and range-check the code against its field width
    always_comb begin
        diff    = $signed(word) - $signed(mid);
        shifted = conv ? (diff >>> stepSize) : diff;
        code    = shifted;
        for (int b = 0; b < NB; b++)
            if (isBool[b]) code[b*BYW +: BYW] = {{(BYW-1){1'b0}}, |shifted[b*BYW +: BYW]};
        // fits in bitWidth signed bits iff everything above the sign bit is a sign copy
        hi        = $signed(code) >>> (bitWidth - 5'd1);
        isOutlier = (bitWidth != 5'd0) && !((hi == '0) || (&hi));
    end
endmodule

module serial_quant_packer #(
    parameter int L2_WIDTH         = 512,
    parameter int WordWidth_WIDTH  = 32,
    parameter int ExponentLength   = 8,
    parameter int NumOfWordsinBlk  = 16,
    parameter int NumOfBytesInWord = 4,
    parameter int LANES            = 1
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    output logic                                          ready,
    input  logic                                          abort,
    input  logic [WordWidth_WIDTH*NumOfWordsinBlk-1:0]    InputWords,
    input  logic [5*NumOfWordsinBlk-1:0]                  bitWidthArray,
    input  logic [WordWidth_WIDTH*NumOfWordsinBlk-1:0]    MidArray,
    input  logic [ExponentLength*NumOfWordsinBlk-1:0]     stepSizeArray,
    input  logic [NumOfWordsinBlk-1:0]                    ConvArray,
    input  logic [NumOfBytesInWord*NumOfWordsinBlk-1:0]   isBoolArray,
    output logic [L2_WIDTH-1:0]                           OutpuStr,
    output logic [$clog2(L2_WIDTH+1)-1:0]                 numberOfValidBits,
    output logic [NumOfWordsinBlk-1:0]                    IsOutlierArray,
    output logic                                          out_valid,
    output logic                                          done
);
    localparam int W  = WordWidth_WIDTH;
    localparam int EL = ExponentLength;
    localparam int NW = NumOfWordsinBlk;
    localparam int NB = NumOfBytesInWord;
    localparam int NG = NW / LANES;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int CW = $clog2(L2_WIDTH + 1);
    localparam int FW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [GW-1:0]     grp;

    // captured block
    logic [W*NW-1:0]   capWords, capMid;
    logic [5*NW-1:0]   capBw;
    logic [EL*NW-1:0]  capStep;
    logic [NW-1:0]     capConv;
    logic [NB*NW-1:0]  capBool;

    // per-lane operands and results for the current group
    logic [LANES-1:0][W-1:0]  laneWord, laneMid, laneCode, laneVal;
    logic [LANES-1:0][4:0]    laneBw;
    logic [LANES-1:0][EL-1:0] laneStep;
    logic [LANES-1:0][NB-1:0] laneBool;
    logic [LANES-1:0]         laneConv, laneOut;
    logic [LANES-1:0][FW-1:0] laneF;
    logic [LANES:0][CW-1:0]   laneOff;

    logic [L2_WIDTH-1:0] packNext;
    logic [NW-1:0]       flagsNext;

    // route the words of group grp onto the lanes
    always_comb begin
        laneWord = '0;
        laneMid  = '0;
        laneBw   = '0;
        laneStep = '0;
        laneConv = '0;
        laneBool = '0;
        for (int g = 0; g < NG; g++) begin
            if (grp == GW'(g)) begin
                for (int j = 0; j < LANES; j++) begin
                    laneWord[j] = capWords[(g*LANES+j)*W +: W];
                    laneMid[j]  = capMid[(g*LANES+j)*W +: W];
                    laneBw[j]   = capBw[(g*LANES+j)*5 +: 5];
                    laneStep[j] = capStep[(g*LANES+j)*EL +: EL];
                    laneConv[j] = capConv[g*LANES+j];
                    laneBool[j] = capBool[(g*LANES+j)*NB +: NB];
                end
            end
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : gLane
        OneWayQuantizer #(.W(W), .EL(EL), .NB(NB)) uQuant (
            .word      (laneWord[j]),
            .mid       (laneMid[j]),
            .stepSize  (laneStep[j]),
            .bitWidth  (laneBw[j]),
            .conv      (laneConv[j]),
            .isBool    (laneBool[j]),
            .code      (laneCode[j]),
            .isOutlier (laneOut[j])
        );
    end

    // field width and masked value per lane, then the offset chain and the packed line
    always_comb begin
        laneOff    = '0;
        laneF      = '0;
        laneVal    = '0;
        laneOff[0] = numberOfValidBits;
        packNext   = OutpuStr;
        for (int j = 0; j < LANES; j++) begin
`ifdef SERIAL_QUANT_RAW_OUTLIER_EN
            if (laneOut[j]) begin
                laneF[j]   = FW'(W);
                laneVal[j] = laneWord[j];
            end else begin
                laneF[j]   = FW'(laneBw[j]);
                laneVal[j] = laneCode[j];
            end
`else
            laneF[j]   = FW'(laneBw[j]);
            laneVal[j] = laneCode[j];
`endif
            if (laneF[j] < FW'(W))
                laneVal[j] = laneVal[j] & ((W'(1) << laneF[j]) - W'(1));
            laneOff[j+1] = laneOff[j] + CW'(laneF[j]);
            // bits above the running count are zero, so OR-ing in never disturbs earlier fields
            packNext = packNext | (L2_WIDTH'(laneVal[j]) << laneOff[j]);
        end
    end

    // outlier flags of the current group land in their word slots
    always_comb begin
        flagsNext = IsOutlierArray;
        for (int k = 0; k < NW; k++)
            if (grp == GW'(k / LANES)) flagsNext[k] = laneOut[k % LANES];
    end

    // control FSM with registered outputs; abort overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            grp               <= '0;
            ready             <= 1'b1;
            done              <= 1'b0;
            out_valid         <= 1'b0;
            OutpuStr          <= '0;
            numberOfValidBits <= '0;
            IsOutlierArray    <= '0;
            capWords          <= '0;
            capMid            <= '0;
            capBw             <= '0;
            capStep           <= '0;
            capConv           <= '0;
            capBool           <= '0;
        end else if (abort) begin
            state             <= IDLE;
            grp               <= '0;
            ready             <= 1'b1;
            done              <= 1'b0;
            out_valid         <= 1'b0;
            OutpuStr          <= '0;
            numberOfValidBits <= '0;
            IsOutlierArray    <= '0;
            capWords          <= '0;
            capMid            <= '0;
            capBw             <= '0;
            capStep           <= '0;
            capConv           <= '0;
            capBool           <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    OutpuStr          <= packNext;
                    numberOfValidBits <= laneOff[LANES];
                    IsOutlierArray    <= flagsNext;
                    if (grp == GW'(NG - 1)) begin
                        state     <= DONE;
                        ready     <= 1'b1;
                        out_valid <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        grp <= grp + GW'(1);
                    end
                end
                default: begin
                    if (start) begin
                        state             <= RUN;
                        grp               <= '0;
                        ready             <= 1'b0;
                        out_valid         <= 1'b0;
                        OutpuStr          <= '0;
                        numberOfValidBits <= '0;
                        IsOutlierArray    <= '0;
                        capWords          <= InputWords;
                        capMid            <= MidArray;
                        capBw             <= bitWidthArray;
                        capStep           <= stepSizeArray;
                        capConv           <= ConvArray;
                        capBool           <= isBoolArray;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_quant_packer.sv
// Directed bench for serial_quant_packer: one LANES=1 and one LANES=4 instance
// sharing the block inputs, each with its own start.
module tb_serial_quant_packer;
    logic clk = 1'b0;
    logic rst_n, start1, start4, abort;
    logic [511:0] words, mids;
    logic [79:0]  bws;
    logic [127:0] steps;
    logic [15:0]  convs;
    logic [63:0]  bools;

    logic         ready1, out_valid1, done1, ready4, out_valid4, done4;
    logic [511:0] str1, str4;
    logic [9:0]   nvb1, nvb4;
    logic [15:0]  outl1, outl4;

    logic [511:0] expStr;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    serial_quant_packer #(.LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .ready(ready1), .abort(abort),
        .InputWords(words), .bitWidthArray(bws), .MidArray(mids),
        .stepSizeArray(steps), .ConvArray(convs), .isBoolArray(bools),
        .OutpuStr(str1), .numberOfValidBits(nvb1), .IsOutlierArray(outl1),
        .out_valid(out_valid1), .done(done1)
    );

    serial_quant_packer #(.LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .ready(ready4), .abort(1'b0),
        .InputWords(words), .bitWidthArray(bws), .MidArray(mids),
        .stepSizeArray(steps), .ConvArray(convs), .isBoolArray(bools),
        .OutpuStr(str4), .numberOfValidBits(nvb4), .IsOutlierArray(outl4),
        .out_valid(out_valid4), .done(done4)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearMeta();
        mids = '0; steps = '0; convs = '0; bools = '0;
    endtask

    // all widths 4, word k = k & 7
    task automatic setUniform();
        clearMeta();
        for (int k = 0; k < 16; k++) begin
            words[32*k +: 32] = 32'(k & 7);
            bws[5*k +: 5]     = 5'd4;
        end
    endtask

    task automatic pulseStart1();
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; abort = 1'b0;
        words = '0; bws = '0; clearMeta();
        tick(2);
        chk("reset_str",   str1, '0);
        chk("reset_nvb",   nvb1, '0);
        chk("reset_valid", out_valid1, '0);
        chk("reset_done",  done1, '0);
        chk("reset_outl",  outl1, '0);
        rst_n = 1'b1;
        tick(1);
        chk("reset_ready", ready1, 1);

        // zero widths
        for (int k = 0; k < 16; k++) words[32*k +: 32] = 32'hA5A5_0000 + 32'(k);
        pulseStart1();
        chk("zero_busy", ready1, 0);
        tick(15);
        chk("zero_valid_early", out_valid1, 0);
        tick(1);
        chk("zero_valid", out_valid1, 1);
        chk("zero_done",  done1, 1);
        chk("zero_ready", ready1, 1);
        chk("zero_nvb",   nvb1, '0);
        chk("zero_str",   str1, '0);
        tick(1);
        chk("zero_done_pulse", done1, 0);
        chk("zero_valid_hold", out_valid1, 1);

        // uniform widths with a start during RUN that must be ignored
        setUniform();
        pulseStart1();
        tick(3);
        words = {16{32'hFFFF_FFFF}};
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        tick(11);
        chk("unif_valid_early", out_valid1, 0);
        tick(1);
        expStr = '0;
        for (int k = 0; k < 16; k++) expStr[4*k +: 4] = 4'(k & 7);
        chk("unif_valid", out_valid1, 1);
        chk("unif_nvb",   nvb1, 10'd64);
        chk("unif_str",   str1, expStr);
        chk("unif_outl",  outl1, '0);

        // mixed widths on the 4-lane instance
        clearMeta();
        words = '0;
        bws   = '0;
        words[31:0]   = 32'd3;            bws[4:0]   = 5'd3;
        words[63:32]  = 32'd100;          bws[9:5]   = 5'd5;
        mids[63:32]   = 32'd90;           convs[1]   = 1'b1; steps[15:8] = 8'd1;
        words[95:64]  = 32'hFFFF_FFFF;    bws[14:10] = 5'd0;
        words[127:96] = 32'h3000_0000;    bws[19:15] = 5'd31;
        for (int k = 4; k < 16; k++) begin
            words[32*k +: 32] = ((k % 2) == 0) ? 32'hFFFF_FFFF : 32'h0;
            bws[5*k +: 5]     = 5'd1;
        end
        start4 = 1'b1;
        tick(1);
        start4 = 1'b0;
        chk("mix_busy", ready4, 0);
        tick(3);
        chk("mix_valid_early", out_valid4, 0);
        tick(1);
        expStr = '0;
        expStr[2:0]  = 3'd3;
        expStr[7:3]  = 5'd5;
        expStr[38:8] = 31'h3000_0000;
        for (int i = 0; i < 6; i++) expStr[39 + 2*i] = 1'b1;
        chk("mix_valid", out_valid4, 1);
        chk("mix_done",  done4, 1);
        chk("mix_nvb",   nvb4, 10'd51);
        chk("mix_str",   str4, expStr);
        chk("mix_outl",  outl4, '0);

        // word 2 is an outlier at width 4
        setUniform();
        words[95:64] = 32'h1234_5678;
        pulseStart1();
        tick(16);
        expStr = '0;
`ifdef SERIAL_QUANT_RAW_OUTLIER_EN
        expStr[3:0]  = 4'd0;
        expStr[7:4]  = 4'd1;
        expStr[39:8] = 32'h1234_5678;
        for (int k = 3; k < 16; k++) expStr[40 + 4*(k-3) +: 4] = 4'(k & 7);
        chk("raw_nvb", nvb1, 10'd92);
`else
        for (int k = 0; k < 16; k++) expStr[4*k +: 4] = 4'(k & 7);
        expStr[11:8] = 4'h8;
        chk("raw_nvb", nvb1, 10'd64);
`endif
        chk("raw_valid", out_valid1, 1);
        chk("raw_str",   str1, expStr);
        chk("raw_outl",  outl1, 16'h0004);

        // abort together with start in DONE: abort wins, stays idle
        abort = 1'b1; start1 = 1'b1;
        tick(1);
        abort = 1'b0; start1 = 1'b0;
        chk("abst_ready", ready1, 1);
        chk("abst_valid", out_valid1, 0);
        chk("abst_nvb",   nvb1, '0);
        chk("abst_str",   str1, '0);
        chk("abst_outl",  outl1, '0);
        tick(1);
        chk("abst_idle", ready1, 1);

        // abort at group 5 (same outlier stimulus)
        pulseStart1();
        tick(5);
`ifdef SERIAL_QUANT_RAW_OUTLIER_EN
        chk("abort_partial_nvb", nvb1, 10'd48);
`else
        chk("abort_partial_nvb", nvb1, 10'd20);
`endif
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_ready", ready1, 1);
        chk("abort_valid", out_valid1, 0);
        chk("abort_done",  done1, 0);
        chk("abort_nvb",   nvb1, '0);
        chk("abort_str",   str1, '0);
        chk("abort_outl",  outl1, '0);
        tick(1);
        chk("abort_idle", ready1, 1);

        // asynchronous reset mid-RUN, then a clean run
        setUniform();
        pulseStart1();
        tick(4);
        chk("rst_partial_nvb", nvb1, 10'd16);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_nvb",   nvb1, '0);
        chk("rst_async_str",   str1, '0);
        chk("rst_async_valid", out_valid1, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        pulseStart1();
        tick(16);
        expStr = '0;
        for (int k = 0; k < 16; k++) expStr[4*k +: 4] = 4'(k & 7);
        chk("rst_rerun_valid", out_valid1, 1);
        chk("rst_rerun_done",  done1, 1);
        chk("rst_rerun_nvb",   nvb1, 10'd64);
        chk("rst_rerun_str",   str1, expStr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
